// File: rtl/pll_scan_sequencer.sv
// Shifts a ROM-held PLL scan-chain image MSB-first, applies it, resets the PLL and qualifies lock.
// Define PLLSEQ_TIMEOUT_EN to enable the scandone/lock timeouts and the sticky error output.
module pll_scan_sequencer #(
    parameter int CHAIN_LEN    = 144,
    parameter int SCAN_DIV     = 2,
    parameter int ARESET_LEN   = 8,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic        clk27,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  cfg_sel,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        pll_scanclk,
    output logic        pll_scanclkena,
    output logic        pll_scandata,
    output logic        pll_configupdate,
    input  logic        pll_scandone,
    output logic        pll_areset,
    input  logic        pll_locked,
    output logic        busy,
    output logic        done,
    output logic        error
);
    localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int EDGE_W = $clog2(CHAIN_LEN + 1);
    localparam int AR_W   = (ARESET_LEN > 1) ? $clog2(ARESET_LEN) : 1;
    localparam logic [DIV_W-1:0]  DIV_RELOAD = DIV_W'(SCAN_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_TOTAL = EDGE_W'(CHAIN_LEN);
    localparam logic [AR_W-1:0]   AR_RELOAD  = AR_W'(ARESET_LEN - 1);
`ifdef PLLSEQ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(LOCK_TIMEOUT + 2);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(LOCK_TIMEOUT);
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_SHIFT, S_UPDATE, S_WAIT_DONE, S_ARESET, S_WAIT_LOCK, S_DONE, S_ERR
    } state_t;

    state_t             r_state;
    logic [1:0]         r_cfg;
    logic [5:0]         r_word_idx;
    logic [15:0]        r_shreg;
    logic [3:0]         r_bit_cnt;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [EDGE_W-1:0]  r_edge_cnt;
    logic [AR_W-1:0]    r_ar_cnt;
    logic [3:0]         r_qual_cnt;
    logic               r_fetch_wait;
    logic               r_scanclk;
    logic               r_scanclkena;
    logic               r_configupdate;
    logic               r_areset;
    logic               r_busy;
    logic               r_done;
    logic [1:0]         r_scandone_sync;
    logic               r_scandone_d;
    logic [1:0]         r_locked_sync;
`ifdef PLLSEQ_TIMEOUT_EN
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic               r_error;
`endif

    logic w_div_tc;
    logic w_scandone_rise;
    logic w_locked;

    assign w_div_tc        = (r_div_cnt == '0);
    assign w_scandone_rise = r_scandone_sync[1] & ~r_scandone_d;
    assign w_locked        = r_locked_sync[1];

    assign rom_addr         = {r_cfg, r_word_idx};
    assign pll_scanclk      = r_scanclk;
    assign pll_scanclkena   = r_scanclkena;
    assign pll_scandata     = r_shreg[15];
    assign pll_configupdate = r_configupdate;
    assign pll_areset       = r_areset;
    assign busy             = r_busy;
    assign done             = r_done;
`ifdef PLLSEQ_TIMEOUT_EN
    assign error            = r_error;
`else
    assign error            = 1'b0;
`endif

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            r_scandone_sync <= 2'b00;
            r_scandone_d    <= 1'b0;
            r_locked_sync   <= 2'b00;
        end else begin
            r_scandone_sync <= {r_scandone_sync[0], pll_scandone};
            r_scandone_d    <= r_scandone_sync[1];
            r_locked_sync   <= {r_locked_sync[0], pll_locked};
        end
    end

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_cfg          <= 2'b00;
            r_word_idx     <= '0;
            r_shreg        <= '0;
            r_bit_cnt      <= '0;
            r_div_cnt      <= '0;
            r_edge_cnt     <= '0;
            r_ar_cnt       <= '0;
            r_qual_cnt     <= '0;
            r_fetch_wait   <= 1'b0;
            r_scanclk      <= 1'b0;
            r_scanclkena   <= 1'b0;
            r_configupdate <= 1'b0;
            r_areset       <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
`ifdef PLLSEQ_TIMEOUT_EN
            r_wait_cnt     <= '0;
            r_error        <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cfg        <= cfg_sel;
                        r_word_idx   <= '0;
                        r_edge_cnt   <= '0;
                        r_fetch_wait <= 1'b0;
                        r_busy       <= 1'b1;
`ifdef PLLSEQ_TIMEOUT_EN
                        r_error      <= 1'b0;
`endif
                        r_state      <= S_FETCH;
                    end
                end
                // ROM is registered: first cycle presents the address, second captures the word
                S_FETCH: begin
                    if (!r_fetch_wait) begin
                        r_fetch_wait <= 1'b1;
                    end else begin
                        r_fetch_wait <= 1'b0;
                        r_shreg      <= rom_data;
                        r_bit_cnt    <= 4'd15;
                        r_div_cnt    <= DIV_RELOAD;
                        r_scanclkena <= 1'b1;
                        r_state      <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (!w_div_tc) begin
                        r_div_cnt <= r_div_cnt - DIV_W'(1);
                    end else begin
                        r_div_cnt <= DIV_RELOAD;
                        r_scanclk <= ~r_scanclk;
                        if (!r_scanclk) begin
                            if (r_edge_cnt != EDGE_TOTAL) r_edge_cnt <= r_edge_cnt + EDGE_W'(1);
                        end else begin
                            r_shreg <= {r_shreg[14:0], 1'b0};
                            if (r_bit_cnt != 4'd0) begin
                                r_bit_cnt <= r_bit_cnt - 4'd1;
                            end else if (r_edge_cnt == EDGE_TOTAL) begin
                                r_scanclkena   <= 1'b0;
                                r_configupdate <= 1'b1;
                                r_state        <= S_UPDATE;
                            end else begin
                                r_word_idx <= r_word_idx + 6'd1;
                                r_state    <= S_FETCH;
                            end
                        end
                    end
                end
                S_UPDATE: begin
                    if (!w_div_tc) begin
                        r_div_cnt <= r_div_cnt - DIV_W'(1);
                    end else begin
                        r_div_cnt <= DIV_RELOAD;
                        r_scanclk <= ~r_scanclk;
                        if (r_scanclk) begin
                            r_configupdate <= 1'b0;
`ifdef PLLSEQ_TIMEOUT_EN
                            r_wait_cnt     <= '0;
`endif
                            r_state        <= S_WAIT_DONE;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (w_scandone_rise) begin
                        r_areset <= 1'b1;
                        r_ar_cnt <= AR_RELOAD;
                        r_state  <= S_ARESET;
                    end
`ifdef PLLSEQ_TIMEOUT_EN
                    else if (r_wait_cnt > WAIT_LIMIT) begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_ERR;
                    end else if (r_wait_cnt != '1) begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
`endif
                end
                S_ARESET: begin
                    if (r_ar_cnt == '0) begin
                        r_areset   <= 1'b0;
                        r_qual_cnt <= '0;
`ifdef PLLSEQ_TIMEOUT_EN
                        r_wait_cnt <= '0;
`endif
                        r_state    <= S_WAIT_LOCK;
                    end else begin
                        r_ar_cnt <= r_ar_cnt - AR_W'(1);
                    end
                end
                // Lock must hold 16 consecutive cycles; a drop restarts qualification only
                S_WAIT_LOCK: begin
                    if (w_locked && r_qual_cnt == 4'd15) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
`ifdef PLLSEQ_TIMEOUT_EN
                    else if (r_wait_cnt > WAIT_LIMIT) begin
                        r_error  <= 1'b1;
                        r_areset <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= S_ERR;
                    end
`endif
                    else begin
                        r_qual_cnt <= w_locked ? r_qual_cnt + 4'd1 : 4'd0;
`ifdef PLLSEQ_TIMEOUT_EN
                        if (r_wait_cnt != '1) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
`endif
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
